pio_irq_debounced: RTL
======================

Name: pio_irq_debounced

Overview:
- Parametrised successor to the fixed 10-bit LED/switch PIO pair in the Qsys system.
- Single Avalon-MM slave combining a generic output port (LEDs) and a generic input port (switches/keys).
- Input port adds:
  - 2-FF synchroniser.
  - Per-bit debounce.
  - Edge capture with runtime-selectable edge type.
  - Maskable level interrupt.
- Output port adds atomic set/clear registers. Sits on the HPS/Nios lightweight bus beside the SDRAM controller.

Parameters:
- IN_WIDTH, 10, input port width (1..32).
- OUT_WIDTH, 10, output port width (1..32).
- DEBOUNCE_CYCLES, 50000, clk_clk cycles an input must be stable before it is accepted (0 = debounce bypassed).
- OUT_RESET, 0, reset value of the output register (OUT_WIDTH bits).

Ports:
- clk_clk  input  1  system clock; all logic on rising edge.
- reset_reset_n  input  1  asynchronous, active-low reset.
- avs_address  input  3  word address.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, registered.
- avs_irq  output  1  level interrupt, active high.
- pio_in  input  IN_WIDTH  asynchronous external inputs.
- pio_out  output  OUT_WIDTH  output register value.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk_clk, reset_reset_n).
- Values while reset_reset_n=0:
  - pio_out=OUT_RESET; avs_readdata=0; avs_irq=0.
  - Sync FFs, debounced value, counters, edge_cap and irq_mask all 0.
  - edge_mode=2'b00.
- Bus timing: no waitrequest. Write takes effect on the clock edge where avs_write=1. Read data is valid exactly 1 cycle after avs_read=1; avs_readdata holds its value otherwise.
- Register map (unused bits read 0, writes to read-only registers ignored):
  - 0 DATA_IN (R): debounced input.
  - 1 DATA_OUT (R/W): output register.
  - 2 OUT_SET (W): out |= wdata. Reads 0.
  - 3 OUT_CLR (W): out &= ~wdata. Reads 0.
  - 4 EDGE_CAP (R/W1C): sticky captured edges; writing 1 clears that bit.
  - 5 IRQ_MASK (R/W): per-bit interrupt enable.
  - 6 EDGE_MODE (R/W, bits 1:0): 00 rising, 01 falling, 10 both, 11 none.
  - 7 CONFIG (R): [5:0]=IN_WIDTH, [13:8]=OUT_WIDTH, [16]=(DEBOUNCE_CYCLES!=0).
- Synchroniser: pio_in passes through 2 flops to give s.
- Debounce (DEBOUNCE_CYCLES>0), per bit i, counter width clog2(DEBOUNCE_CYCLES+1):
  - If s[i]==d[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: d[i]<=s[i], cnt[i]<=0.
  - Else cnt[i]++.
  - Any glitch back to d[i] restarts the count.
  - Latency from a stable pio_in change to d change: 2+DEBOUNCE_CYCLES cycles.
- Debounce bypassed (DEBOUNCE_CYCLES=0): d<=s registered, latency 3 cycles.
- Edge detect: d_prev is d delayed 1 cycle.
  - rise = d & ~d_prev; fall = ~d & d_prev; selected by edge_mode.
  - A detected edge sets edge_cap[i] the cycle after d changes.
- Simultaneous events:
  - W1C and a new edge on the same bit in the same cycle: the set wins, bit stays 1.
  - A write to EDGE_MODE applies from the next cycle and never creates a spurious capture.
- Interrupt: avs_irq is registered, avs_irq <= |(edge_cap & irq_mask). It asserts 1 cycle after edge_cap/mask become nonzero and deasserts 1 cycle after clear or mask.
- Output register: pio_out is driven directly from the output register (no extra latency after the write edge). Writes to DATA_OUT/OUT_SET/OUT_CLR use only bits [OUT_WIDTH-1:0].
- Simultaneous read and write: read returns the pre-write value.
- Reset mid-operation: asynchronous clear of everything, including in-progress debounce counts. After reset release, d starts at 0, so a pio_in held high produces a rising capture once debounced.

Test Plan:
- Reset with OUT_RESET=10'h2AA, pio_in=0 -> pio_out=10'h2AA, avs_irq=0, read addr 7 -> 32'h0001_0A0A (IN=OUT=10, debounce on).
- DEBOUNCE_CYCLES=4:
  - pio_in[0] 0->1 held -> DATA_IN bit0 =1 exactly 6 cycles later.
  - A 3-cycle pulse -> DATA_IN stays 0, EDGE_CAP stays 0.
- Write addr1=0x0F0, addr2=0x003, addr3=0x030 -> pio_out 0x0F0, then 0x0F3, then 0x0C3. Read addr1 -> 0x0C3; read addr2 -> 0.
- EDGE_MODE=01, IRQ_MASK=0x004; pio_in[2] pulse 1->0 -> EDGE_CAP=0x004, avs_irq=1. Write addr4=0x004 -> avs_irq=0 two cycles after the write.
- EDGE_MODE=10 with W1C of bit 1 in the same cycle as a new bit-1 edge -> EDGE_CAP bit1 remains 1, irq stays high.
- Assert reset_reset_n=0 mid-debounce with counter at 2 -> all outputs immediately at reset values. After release, input held high -> capture after 2+DEBOUNCE_CYCLES+1 cycles.

Source files
------------

// File: rtl/pio_irq_debounced.sv
// pio_irq_debounced: Avalon-MM PIO pair with a debounced, edge-capturing input
// port and an output port that has atomic set/clear registers. The input side
// drives a maskable level interrupt built from the captured edges.
module pio_irq_debounced #(
  parameter int                   IN_WIDTH        = 10,
  parameter int                   OUT_WIDTH       = 10,
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 avs_irq,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic DEBOUNCE_ON = (DEBOUNCE_CYCLES != 0);

  localparam logic [2:0] ADDR_DATA_IN   = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT  = 3'd1;
  localparam logic [2:0] ADDR_OUT_SET   = 3'd2;
  localparam logic [2:0] ADDR_OUT_CLR   = 3'd3;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd5;
  localparam logic [2:0] ADDR_EDGE_MODE = 3'd6;
  localparam logic [2:0] ADDR_CONFIG    = 3'd7;

  logic [IN_WIDTH-1:0]  sync_1;
  logic [IN_WIDTH-1:0]  sync_2;
  logic [IN_WIDTH-1:0]  deb;
  logic [IN_WIDTH-1:0]  deb_prev;
  logic [IN_WIDTH-1:0]  edge_cap;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [IN_WIDTH-1:0]  edge_hit;
  logic [IN_WIDTH-1:0]  w1c_bits;
  logic [IN_WIDTH-1:0]  wdata_in;
  logic [OUT_WIDTH-1:0] wdata_out;
  logic [OUT_WIDTH-1:0] out_reg;
  logic [1:0]           edge_mode;
  logic [31:0]          rd_mux;

  // Upper write-data bits beyond the port widths are deliberately ignored.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign wdata_in  = avs_writedata[IN_WIDTH-1:0];
  assign wdata_out = avs_writedata[OUT_WIDTH-1:0];
  assign pio_out   = out_reg;
  assign w1c_bits  = (avs_write && avs_address == ADDR_EDGE_CAP) ? wdata_in : '0;

  // Two-flop synchroniser bringing the asynchronous pins into clk_clk.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= pio_in;
      sync_2 <= sync_1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // With debounce disabled the synchronised value is simply registered.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) deb <= '0;
        else                deb <= sync_2;
      end
    end else begin : g_debounce
      logic [CNT_W-1:0] cnt [IN_WIDTH];

      // Per-bit stability counter; any return to the accepted level restarts it.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          deb <= '0;
          for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < IN_WIDTH; i++) begin
            if (sync_2[i] == deb[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              deb[i] <= sync_2[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  // Select which transitions of the debounced value count as edges.
  always_comb begin
    edge_hit = '0;
    case (edge_mode)
      2'b00:   edge_hit = deb & ~deb_prev;
      2'b01:   edge_hit = ~deb & deb_prev;
      2'b10:   edge_hit = deb ^ deb_prev;
      default: edge_hit = '0;
    endcase
  end

  // Edge capture, interrupt configuration and the registered interrupt line.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_prev  <= '0;
      edge_cap  <= '0;
      irq_mask  <= '0;
      edge_mode <= 2'b00;
      avs_irq   <= 1'b0;
    end else begin
      deb_prev <= deb;
      edge_cap <= (edge_cap & ~w1c_bits) | edge_hit;
      if (avs_write && avs_address == ADDR_IRQ_MASK)  irq_mask  <= wdata_in;
      if (avs_write && avs_address == ADDR_EDGE_MODE) edge_mode <= avs_writedata[1:0];
      avs_irq <= |(edge_cap & irq_mask);
    end
  end

  // Output register with plain, set-bits and clear-bits write ports.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_reg <= OUT_RESET;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_DATA_OUT: out_reg <= wdata_out;
        ADDR_OUT_SET:  out_reg <= out_reg | wdata_out;
        ADDR_OUT_CLR:  out_reg <= out_reg & ~wdata_out;
        default:       out_reg <= out_reg;
      endcase
    end
  end

  // Read multiplexer built from current register state, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA_IN:   rd_mux = 32'(deb);
      ADDR_DATA_OUT:  rd_mux = 32'(out_reg);
      ADDR_EDGE_CAP:  rd_mux = 32'(edge_cap);
      ADDR_IRQ_MASK:  rd_mux = 32'(irq_mask);
      ADDR_EDGE_MODE: rd_mux = {30'd0, edge_mode};
      ADDR_CONFIG:    rd_mux = {15'd0, DEBOUNCE_ON, 2'b00, 6'(OUT_WIDTH), 2'b00, 6'(IN_WIDTH)};
      default:        rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  avs_readdata <= '0;
    else if (avs_read)   avs_readdata <= rd_mux;
  end

endmodule
